// File: rtl/rggen_rtl_pkg.sv
// rggen_rtl_pkg
// Shared bus enumerations used by rggen host adapters and responders.
//   rggen_access : kind of bus request (read, write, posted write)
//   rggen_status : completion status returned with ready
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_READ         = 2'b10,
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

endpackage

// File: rtl/rggen_bus_if.sv
// rggen_bus_if
// Generic register bus between a host adapter (master) and a register
// block or responder (slave).
//   master drives : valid, access, address, write_data, strobe
//   slave drives  : ready, status, read_data
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);

  logic                             valid;
  rggen_rtl_pkg::rggen_access       access;
  logic [ADDRESS_WIDTH-1:0]         address;
  logic [BUS_WIDTH-1:0]             write_data;
  logic [BUS_WIDTH/8-1:0]           strobe;
  logic                             ready;
  rggen_rtl_pkg::rggen_status       status;
  logic [BUS_WIDTH-1:0]             read_data;

  modport master (
    output valid, access, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, access, address, write_data, strobe,
    output ready, status, read_data
  );

endinterface

// File: rtl/rggen_bus_responder_storage.sv
// rggen_bus_responder_storage
// Word array with per-byte strobed write, synchronous clear and
// asynchronous reset. Read port is combinational.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : load every word with INITIAL_VALUE (beats a write)
//   i_write_valid  : apply i_write_data to word i_write_index under i_strobe
//   i_read_index   : word selected onto o_read_data
module rggen_bus_responder_storage #(
  parameter int                   BUS_WIDTH     = 32,
  parameter int                   WORDS         = 16,
  parameter int                   INDEX_WIDTH   = 4,
  parameter logic [BUS_WIDTH-1:0] INITIAL_VALUE = '0
)(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic                   i_write_valid,
  input  logic [INDEX_WIDTH-1:0] i_write_index,
  input  logic [BUS_WIDTH-1:0]   i_write_data,
  input  logic [BUS_WIDTH/8-1:0] i_strobe,
  input  logic [INDEX_WIDTH-1:0] i_read_index,
  output logic [BUS_WIDTH-1:0]   o_read_data
);

  localparam int BYTES = BUS_WIDTH / 8;

  logic [BUS_WIDTH-1:0] word_q [WORDS];
  logic [BYTES-1:0]     byte_we [WORDS];

  // Per-word byte enables: strobe gated by the word select.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word_we
    assign byte_we[gi] = (i_write_valid && (i_write_index == INDEX_WIDTH'(gi)))
                       ? i_strobe : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int w = 0; w < WORDS; w++) begin
        word_q[w] <= INITIAL_VALUE;
      end
    end else if (i_clear) begin
      for (int w = 0; w < WORDS; w++) begin
        word_q[w] <= INITIAL_VALUE;
      end
    end else begin
      for (int w = 0; w < WORDS; w++) begin
        for (int b = 0; b < BYTES; b++) begin
          if (byte_we[w][b]) begin
            word_q[w][8*b+:8] <= i_write_data[8*b+:8];
          end
        end
      end
    end
  end

  // Mux rather than direct indexing so an out-of-range index reads 0.
  always_comb begin
    o_read_data = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (i_read_index == INDEX_WIDTH'(w)) begin
        o_read_data = word_q[w];
      end
    end
  end

endmodule

// File: rtl/rggen_bus_responder.sv
// rggen_bus_responder
// Slave endpoint for rggen_bus_if: a byte-writable word array behind a
// fixed response latency of 1 + WAIT_CYCLES cycles.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : synchronous clear of all words to INITIAL_VALUE
//   o_busy         : high from acceptance through the ready cycle
//   bus_if         : slave modport (request in, ready/status/read_data out)
module rggen_bus_responder
  import rggen_rtl_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 16,
  parameter int                       BUS_WIDTH     = 32,
  parameter int                       WORDS         = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = '0,
  parameter int                       WAIT_CYCLES   = 0,
  parameter logic [BUS_WIDTH-1:0]     INITIAL_VALUE = '0
)(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  output logic       o_busy,
  rggen_bus_if.slave bus_if
);

  localparam int                       BYTE_SHIFT  = $clog2(BUS_WIDTH / 8);
  localparam int                       INDEX_WIDTH = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] WORD_LIMIT  = ADDRESS_WIDTH'(WORDS);
  localparam logic [7:0]               WAIT_COUNT  = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e               state_q;
  logic [7:0]           count_q;
  logic                 ready_q;
  rggen_status          status_q;
  logic [BUS_WIDTH-1:0] read_data_q;

  logic [ADDRESS_WIDTH-1:0] offset;
  logic [ADDRESS_WIDTH-1:0] word_offset;
  logic                     hit;
  logic                     is_write;
  logic                     commit;
  rggen_status              status_d;
  logic [BUS_WIDTH-1:0]     read_data_d;
  logic [BUS_WIDTH-1:0]     storage_read_data;

  // Decode. The offset wraps when address < BASE_ADDRESS, so the explicit
  // lower-bound compare is what rejects those addresses.
  assign offset      = bus_if.address - BASE_ADDRESS;
  assign word_offset = offset >> BYTE_SHIFT;
  assign hit         = (bus_if.address >= BASE_ADDRESS) && (word_offset < WORD_LIMIT);
  assign is_write    = bus_if.access inside {RGGEN_WRITE, RGGEN_POSTED_WRITE};

  // Commit edge = the edge that moves the FSM into RESP. Request fields,
  // the write and the response are all taken on this edge.
  always_comb begin
    commit = 1'b0;
    unique case (state_q)
      ST_IDLE: commit = bus_if.valid && (WAIT_COUNT == 8'd0);
      ST_WAIT: commit = (count_q <= 8'd1);
      default: commit = 1'b0;
    endcase
  end

  // Response is built from storage as it stands before the commit edge, so
  // a read racing a clear still returns the pre-clear word.
  assign status_d    = hit ? RGGEN_OKAY : RGGEN_SLAVE_ERROR;
  assign read_data_d = (hit && !is_write) ? storage_read_data : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      ready_q     <= 1'b0;
      status_q    <= RGGEN_OKAY;
      read_data_q <= '0;
    end else begin
      ready_q     <= 1'b0;
      status_q    <= RGGEN_OKAY;
      read_data_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (commit) begin
            state_q <= ST_RESP;
          end else if (bus_if.valid) begin
            state_q <= ST_WAIT;
            count_q <= WAIT_COUNT;
          end
        end
        ST_WAIT: begin
          if (commit) begin
            state_q <= ST_RESP;
            count_q <= '0;
          end else begin
            count_q <= count_q - 8'd1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
      if (commit) begin
        ready_q     <= 1'b1;
        status_q    <= status_d;
        read_data_q <= read_data_d;
      end
    end
  end

  rggen_bus_responder_storage #(
    .BUS_WIDTH     (BUS_WIDTH),
    .WORDS         (WORDS),
    .INDEX_WIDTH   (INDEX_WIDTH),
    .INITIAL_VALUE (INITIAL_VALUE)
  ) u_storage (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_clear       (i_clear),
    .i_write_valid (commit && hit && is_write),
    .i_write_index (word_offset[INDEX_WIDTH-1:0]),
    .i_write_data  (bus_if.write_data),
    .i_strobe      (bus_if.strobe),
    .i_read_index  (word_offset[INDEX_WIDTH-1:0]),
    .o_read_data   (storage_read_data)
  );

  assign bus_if.ready     = ready_q;
  assign bus_if.status    = status_q;
  assign bus_if.read_data = read_data_q;
  assign o_busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rggen_bus_responder.sv
// tb_rggen_bus_responder
// Directed and random transfers against a word-array reference model.
// dut  : WAIT_CYCLES=2, BASE=0x100, WORDS=4, INITIAL_VALUE=0xDEADBEEF
// dut0 : same but WAIT_CYCLES=0, used for back-to-back throughput.
module tb_rggen_bus_responder;
  import rggen_rtl_pkg::*;

  localparam int          AW    = 16;
  localparam int          DW    = 32;
  localparam int          WORDS = 4;
  localparam int          WAITC = 2;
  localparam logic [15:0] BASE  = 16'h0100;
  localparam logic [31:0] INIT  = 32'hDEAD_BEEF;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic clear  = 1'b0;
  logic clear0 = 1'b0;
  logic busy;
  logic busy0;

  always #5 clk = ~clk;

  rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) bus_a ();
  rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) bus_b ();

  rggen_bus_responder #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .WORDS(WORDS), .BASE_ADDRESS(BASE),
    .WAIT_CYCLES(WAITC), .INITIAL_VALUE(INIT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .o_busy(busy), .bus_if(bus_a)
  );

  rggen_bus_responder #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .WORDS(WORDS), .BASE_ADDRESS(BASE),
    .WAIT_CYCLES(0), .INITIAL_VALUE(INIT)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear0), .o_busy(busy0), .bus_if(bus_b)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] model [WORDS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input logic [15:0] a);
    int off;
    off = int'(a) - int'(BASE);
    return (off >= 0) && ((off / 4) < WORDS);
  endfunction

  function automatic int model_idx(input logic [15:0] a);
    return (int'(a) - int'(BASE)) / 4;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < WORDS; w++) model[w] = INIT;
  endtask

  // One transfer on bus_a. Called just after a rising edge with the DUT idle.
  // clear_cycle: assert i_clear in the cycle reached after that many edges.
  task automatic xfer(input string tag, input logic [15:0] addr, input rggen_access acc,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input int clear_cycle, output logic [31:0] obs_rd);
    int          waited;
    bit          got;
    bit          hit;
    logic [31:0] exp_rd;
    rggen_status exp_st;
    logic [31:0] obs_st;
    waited = 0;
    got    = 0;
    obs_rd = '0;
    obs_st = '0;
    hit    = model_hit(addr);
    exp_st = hit ? RGGEN_OKAY : RGGEN_SLAVE_ERROR;
    exp_rd = (hit && acc == RGGEN_READ) ? model[model_idx(addr)] : 32'h0;

    bus_a.valid      = 1'b1;
    bus_a.access     = acc;
    bus_a.address    = addr;
    bus_a.write_data = wdata;
    bus_a.strobe     = strb;
    while (!got && waited < 20) begin
      @(posedge clk); #1;
      waited++;
      clear = (waited == clear_cycle);
      if (waited == 1) check({tag, ".busy"}, 32'(busy), 32'd1);
      if (bus_a.ready === 1'b1) begin
        got    = 1;
        obs_rd = bus_a.read_data;
        obs_st = 32'(bus_a.status);
      end
    end
    clear = 1'b0;
    check({tag, ".ready_seen"}, 32'(got), 32'd1);
    check({tag, ".latency"}, 32'(waited), 32'(1 + WAITC));
    check({tag, ".status"}, obs_st, 32'(exp_st));
    check({tag, ".rdata"}, obs_rd, exp_rd);

    // Model update: a clear in the cycle before commit discards the write.
    if (clear_cycle == WAITC) begin
      model_reset();
    end else if (hit && acc != RGGEN_READ) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[model_idx(addr)][8*b+:8] = wdata[8*b+:8];
    end

    @(posedge clk); #1;
    bus_a.valid = 1'b0;
    check({tag, ".ready_pulse"}, 32'(bus_a.ready), 32'd0);
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
    $display("xfer %s addr=%h acc=%s wdata=%h strb=%b status=%h rdata=%h lat=%0d",
             tag, addr, acc.name(), wdata, strb, obs_st[1:0], obs_rd, waited);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [15:0] addr;
    rggen_access acc;
    int          k;

    bus_a.valid = 1'b0; bus_a.access = RGGEN_READ; bus_a.address = '0;
    bus_a.write_data = '0; bus_a.strobe = '0;
    bus_b.valid = 1'b0; bus_b.access = RGGEN_READ; bus_b.address = '0;
    bus_b.write_data = '0; bus_b.strobe = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", 32'(bus_a.ready), 32'd0);
    check("rst.status", 32'(bus_a.status), 32'(RGGEN_OKAY));
    check("rst.rdata", bus_a.read_data, 32'h0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.busy0", 32'(busy0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read after reset returns the initial value
    xfer("rd108", 16'h0108, RGGEN_READ, 32'h0, 4'h0, -1, rd);
    check("rd108.const", rd, 32'hDEAD_BEEF);

    // Partial-strobe write then read back
    xfer("wr104", 16'h0104, RGGEN_WRITE, 32'h1234_5678, 4'b0101, -1, rd);
    xfer("rd104", 16'h0104, RGGEN_READ, 32'h0, 4'h0, -1, rd);
    check("rd104.const", rd, 32'hDE34_BE78);

    // Misses below and above the window
    xfer("rd0fc", 16'h00FC, RGGEN_READ, 32'h0, 4'hF, -1, rd);
    xfer("wr110", 16'h0110, RGGEN_WRITE, 32'hA5A5_A5A5, 4'hF, -1, rd);
    for (int w = 0; w < WORDS; w++)
      xfer("rdall", 16'(int'(BASE) + 4 * w), RGGEN_READ, 32'h0, 4'h0, -1, rd);

    // Unaligned address decodes to word 2
    xfer("wr10b", 16'h010B, RGGEN_WRITE, 32'hCAFE_F00D, 4'b1100, -1, rd);
    xfer("rd108b", 16'h0108, RGGEN_READ, 32'h0, 4'h0, -1, rd);
    check("rd108b.const", rd, 32'hCAFE_BEEF);
    xfer("rd10b", 16'h010B, RGGEN_READ, 32'h0, 4'h0, -1, rd);

    // Zero-strobe posted write is a no-op
    xfer("pw0", 16'h010C, RGGEN_POSTED_WRITE, 32'h0000_0000, 4'h0, -1, rd);
    xfer("rd10c", 16'h010C, RGGEN_READ, 32'h0, 4'h0, -1, rd);
    check("rd10c.const", rd, 32'hDEAD_BEEF);

    // Clear in the cycle before commit wins over the write
    xfer("wrclr", 16'h0100, RGGEN_WRITE, 32'hFFFF_FFFF, 4'hF, WAITC, rd);
    xfer("rd100", 16'h0100, RGGEN_READ, 32'h0, 4'h0, -1, rd);
    check("rd100.const", rd, 32'hDEAD_BEEF);
    xfer("rd104c", 16'h0104, RGGEN_READ, 32'h0, 4'h0, -1, rd);
    check("rd104c.const", rd, 32'hDEAD_BEEF);

    // Random traffic against the model
    for (int t = 0; t < 40; t++) begin
      addr = 16'($urandom_range(16'h011F, 16'h00F0));
      k = $urandom_range(2, 0);
      acc = (k == 0) ? RGGEN_READ : (k == 1) ? RGGEN_WRITE : RGGEN_POSTED_WRITE;
      xfer("rand", addr, acc, $urandom, 4'($urandom_range(15, 0)), -1, rd);
    end

    // Make word 1 differ from INIT, then reset in the middle of a write
    xfer("wrpre", 16'h0104, RGGEN_WRITE, 32'h0BAD_0BAD, 4'hF, -1, rd);
    bus_a.valid = 1'b1; bus_a.access = RGGEN_WRITE; bus_a.address = 16'h0108;
    bus_a.write_data = 32'h7777_7777; bus_a.strobe = 4'hF;
    @(posedge clk); #1;
    check("midrst.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.ready", 32'(bus_a.ready), 32'd0);
    bus_a.valid = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("midrst.no_ready", 32'(bus_a.ready), 32'd0);
    end
    for (int w = 0; w < WORDS; w++)
      xfer("rdrst", 16'(int'(BASE) + 4 * w), RGGEN_READ, 32'h0, 4'h0, -1, rd);

    // Back-to-back on the zero-wait instance: ready every second cycle
    bus_b.valid = 1'b1; bus_b.access = RGGEN_READ; bus_b.address = 16'h0104;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("b2b.ready", 32'(bus_b.ready), ((c % 2) == 0) ? 32'd1 : 32'd0);
      if ((c % 2) == 0) check("b2b.rdata", bus_b.read_data, INIT);
      $display("b2b cycle=%0d ready=%b rdata=%h busy=%b", c, bus_b.ready, bus_b.read_data, busy0);
    end
    bus_b.valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rggen_bus_responder.md
# rggen_bus_responder

Slave-side endpoint for `rggen_bus_if`: it terminates a bus driven by a host adapter with a small byte-writable word array and a configurable response latency. It is the responder counterpart to the host adapters that drive the master modport. It serves as a stand-in register block for bring-up and adapter verification, and as a scratch-pad in integrated designs.

## Interface
- `ADDRESS_WIDTH`, 16: bus address width; must match the connected `rggen_bus_if`.
- `BUS_WIDTH`, 32: data width; multiple of 8.
- `WORDS`, 16: number of `BUS_WIDTH` storage words; ≥1.
- `BASE_ADDRESS`, 0: byte address of word 0; aligned to `BUS_WIDTH/8`.
- `WAIT_CYCLES`, 0: extra cycles inserted before `ready`; 0..255.
- `INITIAL_VALUE`, 0: `BUS_WIDTH`-bit reset/clear value of every word.
- `i_clk`, input, 1: clock.
- `i_rst_n`, input, 1: reset; one clock; asynchronous, active-low.
- `i_clear`, input, 1: synchronous clear of all words to `INITIAL_VALUE`.
- `o_busy`, output, 1: high from acceptance through the `ready` cycle.
- `bus_if`, `rggen_bus_if.slave`, -: `valid`/`access`/`address`/`write_data`/`strobe` in; `ready`/`status`/`read_data` out.

## Operation
- Protocol rules:
  - The master holds `valid` and all request fields stable until `valid && ready`.
  - `ready` is a one-cycle pulse. `status` and `read_data` are valid only while `ready` is high.
- Decode:
  - `offset = address - BASE_ADDRESS`; `index = offset >> log2(BUS_WIDTH/8)`. Low byte-offset bits are ignored.
  - Hit: `address >= BASE_ADDRESS` and `index < WORDS`. Otherwise miss.
- Write (`access` = RGGEN_WRITE or RGGEN_POSTED_WRITE):
  - On a hit, byte lane i of word[index] is updated iff `strobe[i]`. Response is RGGEN_OKAY.
  - `strobe` = 0 is legal and is a no-op returning RGGEN_OKAY.
- Read (`access` = RGGEN_READ): on a hit, `read_data` = word[index] and `strobe` is ignored.
- Miss: storage is untouched, `read_data` = 0, status = RGGEN_SLAVE_ERROR.
- FSM:
  - IDLE: `valid` → WAIT if `WAIT_CYCLES`>0, else → RESP.
  - WAIT: down-counter loads `WAIT_CYCLES`; when the counter reaches 1 → RESP.
  - RESP: `ready`=1 → IDLE unconditionally.
- Commit edge: the clock edge entering RESP.
  - The write is applied on that edge.
  - `read_data` and `status` are registered from the storage state before that edge.
- Outside RESP: `ready`=0, `status`=RGGEN_OKAY, `read_data`=0.
- Reset: async assertion forces IDLE, counter 0, all words `INITIAL_VALUE`, `ready`=0, `status`=RGGEN_OKAY, `read_data`=0, `o_busy`=0. This holds mid-transaction too; the pending write is lost.

## Timing
- Request first seen in IDLE at cycle N → `ready` high in cycle N+1+`WAIT_CYCLES`.
- Back-to-back throughput: one transfer per 2+`WAIT_CYCLES` cycles.
- `valid` in the RESP cycle belongs to the completing transfer. A new request is sampled no earlier than the IDLE cycle after RESP.
- Request fields are sampled only on the commit edge. A protocol-compliant master makes that equivalent to sampling at acceptance.
- `i_clear` behaviour:
  - Takes effect on the next edge.
  - If asserted in the cycle before the commit edge, clear wins: the write is discarded, but status is still RGGEN_OKAY. A read in that cycle returns the pre-clear value.
  - In other cycles it does not disturb the FSM.
- `o_busy` = state != IDLE.

## Structure
- Use the shared `rggen_rtl_pkg` `rggen_access`/`rggen_status` enums; add no new package types.
- Local FSM state enum and the `log2(BUS_WIDTH/8)` shift constant stay in the module.
- One sub-module: `rggen_bus_responder_storage`, the word array with per-byte strobe write, clear and async reset. It has a combinational read port.

## Test plan
All scenarios use `BUS_WIDTH`=32, `BASE_ADDRESS`=0x100, `WORDS`=4, `WAIT_CYCLES`=2, `INITIAL_VALUE`=0xDEAD_BEEF.
- Read 0x108 after reset → `ready` exactly 3 cycles after `valid`, `read_data`=0xDEAD_BEEF, RGGEN_OKAY.
- Write 0x104 with `write_data`=0x1234_5678 and `strobe`=4'b0101, then read 0x104 → 0xDE34_BE78.
- Read 0x0FC and write 0x110 → RGGEN_SLAVE_ERROR, `read_data`=0; a later read of every word is unchanged.
- Address 0x10B → decodes to word 2; read/write behave as 0x108.
- `i_clear` on the cycle before the commit edge of a write of 0xFFFF_FFFF, `strobe`=4'hF, to 0x100 → RGGEN_OKAY; a subsequent read returns 0xDEAD_BEEF.
- `i_rst_n` pulsed low in WAIT → `ready`/`o_busy` drop asynchronously, no `ready` follows, storage is reset. With `WAIT_CYCLES`=0 and back-to-back requests, `ready` occurs every 2 cycles.
